// File: rtl/exp3_detector_pkg.sv
// Shared state encodings and default button count for the memory-game play detector.
// No datapath; imported by the detector and its testbench.
package exp3_detector_pkg;

   localparam int N_BOTOES_PADRAO = 4;

   typedef enum logic [3:0] {
      OCIOSO   = 4'h0,
      FILTRA   = 4'h1,
      REGISTRA = 4'h2,
      ESPERA   = 4'h3,
      SOLTA    = 4'h4,
      ERRO     = 4'hE
   } estado_t;

endpackage

// File: rtl/exp3_sincronizador.sv
// Two-flop synchroniser for a bus of independent asynchronous levels.
// Latency 2 cycles; no backpressure, samples every cycle.
module exp3_sincronizador #(
   parameter int LARGURA = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [LARGURA-1:0] entrada,
   output logic [LARGURA-1:0] saida
);

   logic [LARGURA-1:0] estagio1;

   always_ff @(posedge clock) begin
      if (reset) begin
         estagio1 <= '0;
         saida    <= '0;
      end else begin
         estagio1 <= entrada;
         saida    <= estagio1;
      end
   end

endmodule

// File: rtl/exp3_detector_jogada.sv
// Debounced play detector: one jogada pulse per validated press, code held until next press.
// Latency 3 + DEBOUNCE_CICLOS cycles press-to-pulse; no backpressure, gated by habilita only.
// Optional DETECTOR_MULTIPLO_EN rejects multi-button presses with a jogada_invalida pulse.
module exp3_detector_jogada
   import exp3_detector_pkg::*;
#(
   parameter int DEBOUNCE_CICLOS = 50000,
   parameter int N_BOTOES        = N_BOTOES_PADRAO
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                habilita,
   input  logic [N_BOTOES-1:0] botoes,
   output logic                jogada,
   output logic [N_BOTOES-1:0] jogada_codigo,
   output logic                jogada_invalida,
   output logic [3:0]          db_estado
);

   localparam int            CW        = $clog2(DEBOUNCE_CICLOS);
   localparam logic [CW-1:0] CONTA_FIM = CW'(DEBOUNCE_CICLOS - 1);

   estado_t             estado, proximo;
   logic [CW-1:0]       contador;
   logic [N_BOTOES-1:0] botoes_s;
   logic [N_BOTOES-1:0] amostra;
   logic                carrega_amostra;
   logic                conta;
   logic                multiplo;

   exp3_sincronizador #(
      .LARGURA (N_BOTOES)
   ) u_sincronizador (
      .clock   (clock),
      .reset   (reset),
      .entrada (botoes),
      .saida   (botoes_s)
   );

`ifdef DETECTOR_MULTIPLO_EN
   assign multiplo = ($countones(amostra) != 1);
`else
   assign multiplo = 1'b0;
`endif

   always_comb begin
      proximo         = estado;
      carrega_amostra = 1'b0;
      conta           = 1'b0;
      jogada          = 1'b0;
      jogada_invalida = 1'b0;
      db_estado       = estado;
      case (estado)
         OCIOSO: begin
            if (habilita && botoes_s != '0) begin
               proximo         = FILTRA;
               carrega_amostra = 1'b1;
            end
         end
         FILTRA: begin
            // Any pattern change or loss of enable discards the press entirely.
            if (botoes_s != amostra || !habilita)
               proximo = OCIOSO;
            else if (contador == CONTA_FIM)
               proximo = REGISTRA;
            else
               conta = 1'b1;
         end
         REGISTRA: begin
            jogada          = !multiplo;
            jogada_invalida = multiplo;
            proximo         = ESPERA;
         end
         ESPERA: begin
            if (botoes_s == '0)
               proximo = SOLTA;
         end
         SOLTA: begin
            if (botoes_s != '0)
               proximo = ESPERA;
            else if (contador == CONTA_FIM)
               proximo = OCIOSO;
            else
               conta = 1'b1;
         end
         default: begin
            proximo   = OCIOSO;
            db_estado = 4'hE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado        <= OCIOSO;
         contador      <= '0;
         amostra       <= '0;
         jogada_codigo <= '0;
      end else begin
         estado <= proximo;
         // Counter restarts on every state change and only advances below CONTA_FIM.
         if (proximo != estado)
            contador <= '0;
         else if (conta)
            contador <= contador + 1'b1;
         if (carrega_amostra)
            amostra <= botoes_s;
         if (proximo == REGISTRA && !multiplo)
            jogada_codigo <= amostra;
      end
   end

endmodule

// File: tb/tb_exp3_detector_jogada.sv
// Scoreboard bench for exp3_detector_jogada with DEBOUNCE_CICLOS=4.
module tb_exp3_detector_jogada;

   localparam int DB = 4;

   logic       clock = 1'b0;
   logic       reset;
   logic       habilita;
   logic [3:0] botoes;
   logic       jogada;
   logic [3:0] jogada_codigo;
   logic       jogada_invalida;
   logic [3:0] db_estado;

   typedef struct {
      int         ciclo;
      logic [3:0] codigo;
      logic       invalida;
   } esperado_t;

   esperado_t fila[$];
   int        ciclo  = 0;
   int        testes = 0;
   int        falhas = 0;

   exp3_detector_jogada #(
      .DEBOUNCE_CICLOS (DB),
      .N_BOTOES        (4)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .habilita        (habilita),
      .botoes          (botoes),
      .jogada          (jogada),
      .jogada_codigo   (jogada_codigo),
      .jogada_invalida (jogada_invalida),
      .db_estado       (db_estado)
   );

   always #5 clock = ~clock;
   always @(posedge clock) ciclo <= ciclo + 1;

   task automatic verifica(input string tag, input logic [31:0] obtido, input logic [31:0] esperado);
      testes++;
      if (obtido !== esperado) begin
         falhas++;
         $display("FAIL %s: obtido=%0h esperado=%0h (ciclo %0d)", tag, obtido, esperado, ciclo);
      end
   endtask

   task automatic espera_pulso(input int atraso, input logic [3:0] codigo, input logic invalida);
      esperado_t e;
      e.ciclo    = ciclo + atraso;
      e.codigo   = codigo;
      e.invalida = invalida;
      fila.push_back(e);
   endtask

   task automatic aguarda(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Pulse monitor: every pulse must match the head of the scoreboard; overdue entries are misses.
   always @(negedge clock) begin
      if (fila.size() != 0 && fila[0].ciclo < ciclo) begin
         verifica("pulso_perdido", 32'(ciclo), 32'(fila[0].ciclo));
         void'(fila.pop_front());
      end
      if (reset === 1'b0 && (jogada === 1'b1 || jogada_invalida === 1'b1)) begin
         if (fila.size() == 0) begin
            verifica("pulso_inesperado", {30'd0, jogada, jogada_invalida}, 32'd0);
         end else begin
            esperado_t e;
            e = fila.pop_front();
            verifica("pulso_ciclo", 32'(ciclo), 32'(e.ciclo));
            verifica("pulso_codigo", 32'(jogada_codigo), 32'(e.codigo));
            verifica("pulso_jogada", 32'(jogada), 32'(!e.invalida));
            verifica("pulso_invalida", 32'(jogada_invalida), 32'(e.invalida));
         end
      end
   end

   initial begin
      logic [3:0] cod_multi;
      logic       inv_multi;
      int         esp_db;

      // 1: reset with a button held
      reset    = 1'b1;
      habilita = 1'b0;
      botoes   = 4'b0010;
      aguarda(3);
      verifica("t1_jogada", 32'(jogada), 32'd0);
      verifica("t1_invalida", 32'(jogada_invalida), 32'd0);
      verifica("t1_codigo", 32'(jogada_codigo), 32'd0);
      verifica("t1_estado", 32'(db_estado), 32'd0);
      reset  = 1'b0;
      botoes = 4'b0000;
      aguarda(4);

      // 2: clean press, state trace along the debounce
      habilita = 1'b1;
      botoes   = 4'b0100;
      espera_pulso(3 + DB, 4'b0100, 1'b0);
      for (int k = 1; k < 20; k++) begin
         aguarda(1);
         if (k < 3)           esp_db = 0;
         else if (k < 3 + DB) esp_db = 1;
         else if (k == 3 + DB) esp_db = 2;
         else                 esp_db = 3;
         verifica("t2_estado", 32'(db_estado), 32'(esp_db));
      end
      verifica("t2_codigo", 32'(jogada_codigo), 32'b0100);
      botoes = 4'b0000;
      aguarda(10);
      verifica("t2_ocioso", 32'(db_estado), 32'd0);

      // 3: short glitch is filtered out
      botoes = 4'b0001;
      aguarda(2);
      botoes = 4'b0000;
      aguarda(1);
      verifica("t3_filtra", 32'(db_estado), 32'd1);
      aguarda(7);
      verifica("t3_ocioso", 32'(db_estado), 32'd0);
      verifica("t3_codigo", 32'(jogada_codigo), 32'b0100);

      // 4: glitch during release debounce restarts it
      botoes = 4'b1000;
      espera_pulso(3 + DB, 4'b1000, 1'b0);
      aguarda(4 + DB);
      botoes = 4'b0000;
      aguarda(3);
      verifica("t4_solta", 32'(db_estado), 32'd4);
      botoes = 4'b0100;
      aguarda(1);
      botoes = 4'b0000;
      aguarda(2);
      verifica("t4_glitch_espera", 32'(db_estado), 32'd3);
      aguarda(1);
      verifica("t4_resolta", 32'(db_estado), 32'd4);
      aguarda(5);
      verifica("t4_ocioso", 32'(db_estado), 32'd0);
      botoes = 4'b0001;
      espera_pulso(3 + DB, 4'b0001, 1'b0);
      aguarda(9);
      verifica("t4_codigo", 32'(jogada_codigo), 32'b0001);
      botoes = 4'b0000;
      aguarda(12);

      // 5: held press while disabled, then enable
      habilita = 1'b0;
      botoes   = 4'b0010;
      aguarda(10);
      verifica("t5_desab", 32'(db_estado), 32'd0);
      habilita = 1'b1;
      espera_pulso(1 + DB, 4'b0010, 1'b0);
      aguarda(7);
      verifica("t5_codigo", 32'(jogada_codigo), 32'b0010);
      botoes = 4'b0000;
      aguarda(12);

      // 6: two buttons at once, then reset mid-debounce
`ifdef DETECTOR_MULTIPLO_EN
      cod_multi = 4'b0010;
      inv_multi = 1'b1;
`else
      cod_multi = 4'b0011;
      inv_multi = 1'b0;
`endif
      botoes = 4'b0011;
      espera_pulso(3 + DB, cod_multi, inv_multi);
      aguarda(9);
      verifica("t6_codigo", 32'(jogada_codigo), 32'(cod_multi));
      botoes = 4'b0000;
      aguarda(12);
      botoes = 4'b0100;
      aguarda(4);
      verifica("t6_filtra", 32'(db_estado), 32'd1);
      reset  = 1'b1;
      botoes = 4'b0000;
      aguarda(1);
      verifica("t6_reset_estado", 32'(db_estado), 32'd0);
      verifica("t6_reset_codigo", 32'(jogada_codigo), 32'd0);
      reset = 1'b0;
      aguarda(10);
      verifica("fila_vazia", 32'(fila.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", testes, falhas);
      $finish;
   end

endmodule
